// File: rtl/mem_arb.sv
// Single-port memory arbiter/sequencer: fetch vs data requester, fixed wait-state window, one-cycle ack.
// Define MYCPU_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_arb #(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req_in,
  input  logic [AW-1:0] if_addr_in,
  output logic          if_ack_out,
  output logic [DW-1:0] if_rdata_out,
  input  logic          d_req_in,
  input  logic          d_we_in,
  input  logic [AW-1:0] d_addr_in,
  input  logic [DW-1:0] d_wdata_in,
  output logic          d_ack_out,
  output logic [DW-1:0] d_rdata_out,
  output logic          mem_en_out,
  output logic          mem_we_out,
  output logic [AW-1:0] mem_addr_out,
  output logic [DW-1:0] mem_wdata_out,
  input  logic [DW-1:0] mem_rdata_in,
  output logic          busy_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       sel_d;    // current winner is the data requester
  logic       grant_d;

`ifdef MYCPU_ARB_RR_EN
  logic last_d;         // last grant went to data; reset value means fetch

  // On a tie the requester not granted last wins; a lone requester always wins.
  always_comb begin
    // NOTE: a default assignment first keeps this block free of inferred latches.
    grant_d = 1'b0;
    if (d_req_in && (!if_req_in || !last_d)) grant_d = 1'b1;
  end
`else
  always_comb begin
    grant_d = 1'b0;
    if (d_req_in) grant_d = 1'b1;
  end
`endif

  // The mem_* registers double as the latched operands, so they stay stable through ACCESS.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      sel_d         <= 1'b0;
      if_ack_out    <= 1'b0;
      if_rdata_out  <= '0;
      d_ack_out     <= 1'b0;
      d_rdata_out   <= '0;
      mem_en_out    <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      busy_out      <= 1'b0;
`ifdef MYCPU_ARB_RR_EN
      last_d        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (if_req_in || d_req_in) begin
            state         <= ACCESS;
            cnt           <= 4'(WAIT_CYCLES);
            sel_d         <= grant_d;
            busy_out      <= 1'b1;
            mem_en_out    <= 1'b1;
            mem_we_out    <= grant_d & d_we_in;
            mem_addr_out  <= grant_d ? d_addr_in : if_addr_in;
            mem_wdata_out <= grant_d ? d_wdata_in : mem_wdata_out;
`ifdef MYCPU_ARB_RR_EN
            last_d        <= grant_d;
`endif
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            mem_en_out <= 1'b0;
            mem_we_out <= 1'b0;
            if (sel_d) begin
              d_ack_out <= 1'b1;
              if (!mem_we_out) d_rdata_out <= mem_rdata_in;
            end else begin
              if_ack_out   <= 1'b1;
              if_rdata_out <= mem_rdata_in;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          if_ack_out <= 1'b0;
          d_ack_out  <= 1'b0;
          busy_out   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: WAIT_CYCLES=2 instance for the main tests, WAIT_CYCLES=0 instance for back-to-back.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_ack, d_ack, mem_en, mem_we, busy;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  logic        if_req_z, d_req_z, d_we_z;
  logic [15:0] if_addr_z, d_addr_z, d_wdata_z, mem_rdata_z;
  logic        if_ack_z, d_ack_z, mem_en_z, mem_we_z, busy_z;
  logic [15:0] if_rdata_z, d_rdata_z, mem_addr_z, mem_wdata_z;

  mem_arb #(.AW(16), .DW(16), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_in(if_req), .if_addr_in(if_addr), .if_ack_out(if_ack), .if_rdata_out(if_rdata),
    .d_req_in(d_req), .d_we_in(d_we), .d_addr_in(d_addr), .d_wdata_in(d_wdata),
    .d_ack_out(d_ack), .d_rdata_out(d_rdata),
    .mem_en_out(mem_en), .mem_we_out(mem_we), .mem_addr_out(mem_addr),
    .mem_wdata_out(mem_wdata), .mem_rdata_in(mem_rdata), .busy_out(busy)
  );

  mem_arb #(.AW(16), .DW(16), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst_n(rst_n),
    .if_req_in(if_req_z), .if_addr_in(if_addr_z), .if_ack_out(if_ack_z), .if_rdata_out(if_rdata_z),
    .d_req_in(d_req_z), .d_we_in(d_we_z), .d_addr_in(d_addr_z), .d_wdata_in(d_wdata_z),
    .d_ack_out(d_ack_z), .d_rdata_out(d_rdata_z),
    .mem_en_out(mem_en_z), .mem_we_out(mem_we_z), .mem_addr_out(mem_addr_z),
    .mem_wdata_out(mem_wdata_z), .mem_rdata_in(mem_rdata_z), .busy_out(busy_z)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {59'd0, if_ack, d_ack, mem_en, mem_we, busy}, 64'd0);
    check({tag, "_if_rdata"}, {48'd0, if_rdata}, 64'd0);
    check({tag, "_d_rdata"}, {48'd0, d_rdata}, 64'd0);
    check({tag, "_mem_addr"}, {48'd0, mem_addr}, 64'd0);
    check({tag, "_mem_wdata"}, {48'd0, mem_wdata}, 64'd0);
  endtask

  // One access on the WAIT_CYCLES=2 instance; index i counts edges after the grant edge E0.
  task automatic run_txn(input logic is_d, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] rdata,
                         output int en_n, output int we_n, output int ack_at, output int ack_n,
                         output int other_n, output int bad_n, output logic [15:0] rd_at_ack);
    en_n = 0; we_n = 0; ack_at = -1; ack_n = 0; other_n = 0; bad_n = 0; rd_at_ack = '0;
    mem_rdata = rdata;
    if (is_d) begin
      d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      if (mem_en) begin
        en_n++;
        if (mem_addr !== addr || (we && mem_wdata !== wdata)) bad_n++;
      end
      if (mem_we) we_n++;
      if (is_d ? d_ack : if_ack) begin
        ack_n++;
        if (ack_at < 0) ack_at = i;
        rd_at_ack = is_d ? d_rdata : if_rdata;
        if (is_d) d_req = 1'b0; else if_req = 1'b0;
      end
      if (is_d ? if_ack : d_ack) other_n++;
      @(posedge clk); #1;
    end
    d_req = 1'b0; if_req = 1'b0;
  endtask

  // Waits for the next ack on the WAIT_CYCLES=2 instance; which: 1=data, 2=fetch, 0=timeout.
  task automatic wait_ack(output int which, output int cycles);
    which = 0; cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (d_ack) begin which = 1; break; end
      if (if_ack) begin which = 2; break; end
    end
  endtask

  int          en_n, we_n, ack_at, ack_n, other_n, bad_n, which, cyc, acks_seen;
  int          first_z, second_z;
  logic [15:0] rd, rd1_z, rd2_z, addr2_z;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    if_req_z = 0; d_req_z = 0; d_we_z = 0; if_addr_z = 0; d_addr_z = 0; d_wdata_z = 0; mem_rdata_z = 0;
    #1;
    check_all_zero("reset");
    check("reset_z_ctl", {59'd0, if_ack_z, d_ack_z, mem_en_z, mem_we_z, busy_z}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", {63'd0, busy}, 64'd0);

    // Fetch read
    run_txn(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5A5, en_n, we_n, ack_at, ack_n, other_n, bad_n, rd);
    check("fetch_en_cycles", en_n, 3);
    check("fetch_we_cycles", we_n, 0);
    check("fetch_ack_edge", ack_at, 3);
    check("fetch_ack_len", ack_n, 1);
    check("fetch_other_ack", other_n, 0);
    check("fetch_addr_stable", bad_n, 0);
    check("fetch_rdata_at_ack", rd, 16'hA5A5);
    check("fetch_if_rdata", if_rdata, 16'hA5A5);
    check("fetch_d_rdata", d_rdata, 16'h0000);

    // Data write
    run_txn(1'b1, 1'b1, 16'h0100, 16'h1234, 16'hFFFF, en_n, we_n, ack_at, ack_n, other_n, bad_n, rd);
    check("wr_en_cycles", en_n, 3);
    check("wr_we_cycles", we_n, 3);
    check("wr_ack_edge", ack_at, 3);
    check("wr_ack_len", ack_n, 1);
    check("wr_other_ack", other_n, 0);
    check("wr_addr_wdata", bad_n, 0);
    check("wr_d_rdata", d_rdata, 16'h0000);
    check("wr_if_rdata", if_rdata, 16'hA5A5);

    // Simultaneous requests: data first, fetch waits a full access, then data again
    d_we = 1'b0; d_addr = 16'h0200; if_addr = 16'h0020; mem_rdata = 16'h1111;
    d_req = 1'b1; if_req = 1'b1;
    wait_ack(which, cyc);
    check("tie_first_winner", which, 1);
    check("tie_first_latency", cyc, 4);
    check("tie_first_d_rdata", d_rdata, 16'h1111);
    d_req = 1'b0; mem_rdata = 16'h2222;
    wait_ack(which, cyc);
    check("tie_second_winner", which, 2);
    check("tie_second_gap", cyc, 5);
    check("tie_second_if_rdata", if_rdata, 16'h2222);
    check("tie_second_d_rdata", d_rdata, 16'h1111);
    if_req = 1'b0; d_addr = 16'h0202; mem_rdata = 16'h3333; d_req = 1'b1;
    wait_ack(which, cyc);
    check("tie_third_winner", which, 1);
    check("tie_third_gap", cyc, 5);
    check("tie_third_d_rdata", d_rdata, 16'h3333);
    check("tie_third_if_rdata", if_rdata, 16'h2222);
    d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset during the second ACCESS cycle
    d_we = 1'b0; d_addr = 16'h0400; mem_rdata = 16'hBEEF; d_req = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_first_access", {63'd0, mem_en}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; d_req = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    acks_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (d_ack || if_ack) acks_seen++;
    end
    check("rst_mid_no_ack", acks_seen, 0);
    check("rst_mid_idle", {63'd0, busy}, 64'd0);
    run_txn(1'b0, 1'b0, 16'h0044, 16'h0000, 16'h5555, en_n, we_n, ack_at, ack_n, other_n, bad_n, rd);
    check("rst_after_ack_edge", ack_at, 3);
    check("rst_after_ack_len", ack_n, 1);
    check("rst_after_if_rdata", if_rdata, 16'h5555);

    // WAIT_CYCLES=0 back-to-back data reads
    d_we_z = 1'b0; d_addr_z = 16'h0300; mem_rdata_z = 16'h0C0C; d_req_z = 1'b1;
    first_z = -1; second_z = -1; rd1_z = '0; rd2_z = '0; addr2_z = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      if (d_ack_z) begin
        if (first_z < 0) begin first_z = i; rd1_z = d_rdata_z; end
        else if (second_z < 0) begin second_z = i; rd2_z = d_rdata_z; end
      end
      if (i == 3 && mem_en_z) addr2_z = mem_addr_z;
      if (i == 2) begin d_addr_z = 16'h0301; mem_rdata_z = 16'h0D0D; end
      if (i == 4) d_req_z = 1'b0;
      @(posedge clk); #1;
    end
    d_req_z = 1'b0;
    check("w0_first_ack_edge", first_z, 1);
    check("w0_first_rdata", rd1_z, 16'h0C0C);
    check("w0_second_ack_edge", second_z, 4);
    check("w0_second_rdata", rd2_z, 16'h0D0D);
    check("w0_second_addr", addr2_z, 16'h0301);
    check("w0_if_rdata", if_rdata_z, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
